// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-control definitions.
// Holds the sequencer state encodings, the next-PC select codes (the fetch stage's PC mux
// decodes the same values) and the redirect-detect helper.
package cpu_pkg;

    // Values are visible on state_o for debug, so the encoding is fixed.
    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_e;

    localparam logic [1:0] SEL_PC4  = 2'b00;  // sequential PC+4
    localparam logic [1:0] SEL_JUMP = 2'b01;  // jump_exe target
    localparam logic [1:0] SEL_REG  = 2'b10;  // DOA_exe register target
    localparam logic [1:0] SEL_ZERO = 2'b11;  // boot vector

    // A valid execute-stage jump, or a taken conditional branch, redirects fetch.
    function automatic logic redirect_of(input logic valid, input logic jal, input logic jalr,
                                         input logic branch, input logic taken);
        return valid & (jal | jalr | (branch & taken));
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its neighbours.
// master: the sequencer (reads execute/hazard/imem status, drives PC control).
// slave : the surroundings (drive status, observe PC control and debug outputs).
// Inputs : exe_valid, exe_jal, exe_jalr, exe_branch, exe_taken, hazard_stall, imem_ack,
//          halt_req, restart.
// Outputs: SEL_DIR, pc_en, imem_req, flush_if, flush_id, fetch_err, redirect_cnt, state_o.
interface fetch_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             exe_valid;
    logic             exe_jal;
    logic             exe_jalr;
    logic             exe_branch;
    logic             exe_taken;
    logic             hazard_stall;
    logic             imem_ack;
    logic             halt_req;
    logic             restart;

    logic [1:0]       SEL_DIR;
    logic             pc_en;
    logic             imem_req;
    logic             flush_if;
    logic             flush_id;
    logic             fetch_err;
    logic [CNT_W-1:0] redirect_cnt;
    logic [1:0]       state_o;

    modport master (
        input  exe_valid, exe_jal, exe_jalr, exe_branch, exe_taken,
        input  hazard_stall, imem_ack, halt_req, restart,
        output SEL_DIR, pc_en, imem_req, flush_if, flush_id,
        output fetch_err, redirect_cnt, state_o
    );

    modport slave (
        output exe_valid, exe_jal, exe_jalr, exe_branch, exe_taken,
        output hazard_stall, imem_ack, halt_req, restart,
        input  SEL_DIR, pc_en, imem_req, flush_if, flush_id,
        input  fetch_err, redirect_cnt, state_o
    );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter.
// Ports: clk (rising edge), rst_n (async active-low), inc (count one event), clear (sync
// zero, wins over inc), count (current value, holds at all-ones).
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: picks the next-PC source and PC load enable through boot, sequential
// fetch, redirect + flush, hazard stalls, imem wait states and halt.
// Ports: reloj (clock, rising edge), reset (async active-low), bus (fetch_sequencer_if.master:
// execute/hazard/imem/halt status in, SEL_DIR/pc_en/imem_req/flush_if/flush_id out, plus the
// sticky fetch_err, the saturating redirect_cnt and state_o for debug).
// bus must be instantiated with the same CNT_W as this module.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,   // 1..7
    parameter int unsigned TIMEOUT      = 16,  // 2..255
    parameter int unsigned CNT_W        = 16
) (
    input  logic          reloj,
    input  logic          reset,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] DRAIN_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] drain_q, drain_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       redirect_inc;
    logic       redirect;

    logic [1:0] sel_dir;
    logic       pc_en;
    logic       imem_req;
    logic       flush_if;
    logic       flush_id;

    logic [CNT_W-1:0] redirect_cnt;

    assign redirect = redirect_of(bus.exe_valid, bus.exe_jal, bus.exe_jalr,
                                  bus.exe_branch, bus.exe_taken);

    // State and counter registers.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            drain_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next state. wait_q counts consecutive unacknowledged request cycles of one fetch, so it
    // restarts whenever a fetch completes or fetching is abandoned.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        wait_d       = wait_q;
        err_d        = err_q;
        redirect_inc = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                wait_d  = '0;
            end
            FETCH: begin
                if (bus.halt_req) begin
                    state_d = HALT;
                    wait_d  = '0;
                end else if (redirect) begin
                    state_d      = DRAIN;
                    drain_d      = DRAIN_INIT;
                    wait_d       = '0;
                    redirect_inc = 1'b1;
                end else if (bus.hazard_stall) begin
                    wait_d = wait_q;
                end else if (bus.imem_ack) begin
                    wait_d = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DRAIN: begin
                // Redirects and acks here belong to squashed work and are ignored.
                if (bus.halt_req) begin
                    state_d = HALT;
                end else if (drain_q == 3'd0) begin
                    state_d = FETCH;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            HALT: begin
                if (bus.restart) begin
                    state_d = BOOT;
                    err_d   = 1'b0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Outputs, combinational from state and inputs.
    always_comb begin
        sel_dir  = SEL_PC4;
        pc_en    = 1'b0;
        imem_req = 1'b0;
        flush_if = 1'b0;
        flush_id = 1'b0;
        unique case (state_q)
            BOOT: begin
                sel_dir  = SEL_ZERO;
                pc_en    = 1'b1;
                flush_if = 1'b1;
                flush_id = 1'b1;
            end
            FETCH: begin
                if (bus.halt_req) begin
                    imem_req = 1'b0;
                end else if (redirect) begin
                    // flush_if also drops an imem word arriving on this edge.
                    sel_dir  = bus.exe_jalr ? SEL_REG : SEL_JUMP;
                    pc_en    = 1'b1;
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (bus.hazard_stall) begin
                    imem_req = 1'b1;
                end else if (bus.imem_ack) begin
                    pc_en    = 1'b1;
                    imem_req = 1'b1;
                end else begin
                    imem_req = 1'b1;
                end
            end
            DRAIN: begin
                flush_if = 1'b1;
            end
            HALT: begin
                imem_req = 1'b0;
            end
            default: begin
                sel_dir = SEL_PC4;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_redirect_cnt (
        .clk   (reloj),
        .rst_n (reset),
        .inc   (redirect_inc),
        .clear (1'b0),
        .count (redirect_cnt)
    );

    assign bus.SEL_DIR      = sel_dir;
    assign bus.pc_en        = pc_en;
    assign bus.imem_req     = imem_req;
    assign bus.flush_if     = flush_if;
    assign bus.flush_id     = flush_id;
    assign bus.fetch_err    = err_q;
    assign bus.redirect_cnt = redirect_cnt;
    assign bus.state_o      = state_q;

endmodule
